// File: rtl/btn_debounce_multi.sv
// Multi-channel button debouncer: shared sample prescaler, press/release/long-press pulses; auto-repeat under BTN_AUTOREPEAT_EN.
// Latency: 2 sync cycles + wait for next tick + (DEPTH-1) ticks to btn_out; event pulses coincide with the new level.
// Backpressure: none, free-running; outputs are level/pulse only.
module btn_debounce_multi #(
  parameter int CHANNELS     = 2,
  parameter int CLK_DIV      = 100000,
  parameter int DEPTH        = 8,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 50,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_out,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic          AL       = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

  logic [CHANNELS-1:0]             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CHANNELS-1:0]             samp;
  logic [CW-1:0]                   div_q, div_d;
  logic                            tick_w;
  // Only DEPTH-1 past samples are stored; the current sample completes the window.
  logic [CHANNELS-1:0][DEPTH-2:0]  hist_q, hist_d;
  logic [CHANNELS-1:0]             btn_q, btn_d;
  logic [CHANNELS-1:0]             press_q, press_d;
  logic [CHANNELS-1:0]             rel_q, rel_d;
  logic [CHANNELS-1:0]             long_q, long_d;
  logic [CHANNELS-1:0][HW-1:0]     hold_q, hold_d;

  always_comb begin
    logic [DEPTH-1:0] sh_n;
    logic [HW-1:0]    hold_inc;
    sh_n     = '0;
    hold_inc = '0;
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    samp     = sync2_q ^ {CHANNELS{AL}};
    tick_w   = (div_q == DIV_LAST);
    div_d    = tick_w ? '0 : div_q + 1'b1;
    hist_d   = hist_q;
    btn_d    = btn_q;
    hold_d   = hold_q;
    long_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sh_n = {hist_q[i], samp[i]};
      if (tick_w) begin
        hist_d[i] = sh_n[DEPTH-2:0];
        if (&sh_n) begin
          btn_d[i] = 1'b1;
        end else if (~|sh_n) begin
          btn_d[i] = 1'b0;
        end
      end
      // Hold time counts from the registered level, so the rising tick is excluded.
      hold_inc = hold_q[i] + 1'b1;
      if (!btn_q[i]) begin
        hold_d[i] = '0;
      end else if (tick_w && (hold_q[i] != HOLD_MAX)) begin
        hold_d[i] = hold_inc;
        long_d[i] = (hold_inc == HOLD_MAX);
      end
    end
    press_d = btn_d & ~btn_q;
    rel_d   = ~btn_d & btn_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= {CHANNELS{AL}};
      sync2_q <= {CHANNELS{AL}};
      div_q   <= '0;
      hist_q  <= '0;
      btn_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      hold_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      div_q   <= div_d;
      hist_q  <= hist_d;
      btn_q   <= btn_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      hold_q  <= hold_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_TICKS - 1);

  logic [CHANNELS-1:0][RW-1:0] rpt_q, rpt_d;
  logic [CHANNELS-1:0]         rep_q, rep_d;

  always_comb begin
    rpt_d = rpt_q;
    rep_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // Armed only once the hold counter has saturated and the long pulse is past.
      if (!btn_d[i] || long_q[i]) begin
        rpt_d[i] = '0;
      end else if (tick_w && (hold_q[i] == HOLD_MAX)) begin
        if (rpt_q[i] == RPT_LAST) begin
          rpt_d[i] = '0;
          rep_d[i] = 1'b1;
        end else begin
          rpt_d[i] = rpt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rpt_q <= '0;
      rep_q <= '0;
    end else begin
      rpt_q <= rpt_d;
      rep_q <= rep_d;
    end
  end

  assign repeat_pulse = rep_q;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_TICKS > 0);
  assign repeat_pulse      = '0;
`endif

  assign btn_out       = btn_q;
  assign press         = press_q;
  assign release_pulse = rel_q;
  assign long_press    = long_q;
  assign tick          = tick_w;

endmodule
